// File: rtl/reg_file_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_pkg
// Description : Shared state encoding and default sizing for the register file.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_file_pkg;

    localparam int c_DATA_W   = 16;
    localparam int c_ADDR_W   = 4;
    localparam int c_ZERO_REG = 1;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/reg_file_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_scoreboard
// Description : Per-entry busy bits with issue set, write-back clear and
//               same-cycle clear bypass on the lookup ports.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_scoreboard #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_set_en,
    input  logic [ADDR_W-1:0] i_set_addr,
    input  logic              i_clr0_en,
    input  logic [ADDR_W-1:0] i_clr0_addr,
    input  logic              i_clr1_en,
    input  logic [ADDR_W-1:0] i_clr1_addr,
    input  logic [ADDR_W-1:0] i_lk_addr1,
    input  logic [ADDR_W-1:0] i_lk_addr2,
    output logic              o_busy1,
    output logic              o_busy2
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] r_busy;
    logic             w_clr_hit1;
    logic             w_clr_hit2;

    // Set is applied last so a new producer outranks a retiring one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            if (i_clr0_en) r_busy[i_clr0_addr] <= 1'b0;
            if (i_clr1_en) r_busy[i_clr1_addr] <= 1'b0;
            if (i_set_en)  r_busy[i_set_addr]  <= 1'b1;
        end
    end

    assign w_clr_hit1 = ((i_clr0_en && i_clr0_addr == i_lk_addr1) ||
                         (i_clr1_en && i_clr1_addr == i_lk_addr1)) &&
                        !(i_set_en && i_set_addr == i_lk_addr1);
    assign w_clr_hit2 = ((i_clr0_en && i_clr0_addr == i_lk_addr2) ||
                         (i_clr1_en && i_clr1_addr == i_lk_addr2)) &&
                        !(i_set_en && i_set_addr == i_lk_addr2);

    assign o_busy1 = w_clr_hit1 ? 1'b0 : r_busy[i_lk_addr1];
    assign o_busy2 = w_clr_hit2 ? 1'b0 : r_busy[i_lk_addr2];

endmodule
`default_nettype wire

// File: rtl/reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_sb
// Description : 2R/2W register file with write bypass, post-reset sequential
//               clear and issue/write-back scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = c_DATA_W,
    parameter int ADDR_W   = c_ADDR_W,
    parameter int ZERO_REG = c_ZERO_REG
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              ready,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_busy1,
    output logic              rd_busy2,
    input  logic              wr_en0,
    input  logic [ADDR_W-1:0] wr_addr0,
    input  logic [DATA_W-1:0] wr_data0,
    input  logic              wr_en1,
    input  logic [ADDR_W-1:0] wr_addr1,
    input  logic [DATA_W-1:0] wr_data1,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr
);

    localparam int DEPTH = 1 << ADDR_W;

    state_t            r_state;
    logic [ADDR_W-1:0] r_clr_ptr;
    logic              r_ready;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_we0;
    logic              w_we1;
    logic              w_iss;
    logic              w_sb_busy1;
    logic              w_sb_busy2;

    function automatic logic is_zero(input logic [ADDR_W-1:0] addr);
        return (ZERO_REG != 0) && (addr == '0);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= CLEAR;
            r_clr_ptr <= '0;
            r_ready   <= 1'b0;
        end else begin
            case (r_state)
                CLEAR: begin
                    r_clr_ptr <= r_clr_ptr + ADDR_W'(1);
                    if (r_clr_ptr == ADDR_W'(DEPTH - 1)) begin
                        r_state <= RUN;
                        r_ready <= 1'b1;
                    end
                end
                RUN: begin
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= CLEAR;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign ready = r_ready;

    // Traffic is dropped until the clear sweep finishes; entry 0 never accepts.
    assign w_we0 = r_ready && wr_en0 && !is_zero(wr_addr0);
    assign w_we1 = r_ready && wr_en1 && !is_zero(wr_addr1);
    assign w_iss = r_ready && iss_en && !is_zero(iss_addr);

    // Port 1 is written second so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (r_state == CLEAR) begin
            r_mem[r_clr_ptr] <= '0;
        end else begin
            if (w_we0) r_mem[wr_addr0] <= wr_data0;
            if (w_we1) r_mem[wr_addr1] <= wr_data1;
        end
    end

    assign rd_data1 = (!r_ready || is_zero(rd_addr1))    ? '0       :
                      (w_we1 && wr_addr1 == rd_addr1)    ? wr_data1 :
                      (w_we0 && wr_addr0 == rd_addr1)    ? wr_data0 :
                                                           r_mem[rd_addr1];
    assign rd_data2 = (!r_ready || is_zero(rd_addr2))    ? '0       :
                      (w_we1 && wr_addr1 == rd_addr2)    ? wr_data1 :
                      (w_we0 && wr_addr0 == rd_addr2)    ? wr_data0 :
                                                           r_mem[rd_addr2];

    reg_file_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_set_en    (w_iss),
        .i_set_addr  (iss_addr),
        .i_clr0_en   (w_we0),
        .i_clr0_addr (wr_addr0),
        .i_clr1_en   (w_we1),
        .i_clr1_addr (wr_addr1),
        .i_lk_addr1  (rd_addr1),
        .i_lk_addr2  (rd_addr2),
        .o_busy1     (w_sb_busy1),
        .o_busy2     (w_sb_busy2)
    );

    assign rd_busy1 = r_ready && !is_zero(rd_addr1) && w_sb_busy1;
    assign rd_busy2 = r_ready && !is_zero(rd_addr2) && w_sb_busy2;

endmodule
`default_nettype wire

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the register width in bits.
REQ-002 Parameter ADDR_W, default 4, SHALL set the address width; DEPTH = 2**ADDR_W entries.
REQ-003 Parameter ZERO_REG, default 1, SHALL make entry 0 hard-wired to zero when 1.
REQ-004 clk  in  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-005 rst_n  in  1  SHALL be the reset: synchronous, active-low.
REQ-006 ready  out  1  SHALL be high when the post-reset clear is complete.
REQ-007 rd_addr1, rd_addr2  in  ADDR_W  SHALL be the read-port addresses.
REQ-008 rd_data1, rd_data2  out  DATA_W  SHALL be the combinational read data.
REQ-009 rd_busy1, rd_busy2  out  1  SHALL be the scoreboard busy bit of the addressed entry.
REQ-010 wr_en0, wr_addr0 (ADDR_W), wr_data0 (DATA_W)  in  SHALL form write port 0 (ALU write-back).
REQ-011 wr_en1, wr_addr1 (ADDR_W), wr_data1 (DATA_W)  in  SHALL form write port 1 (load write-back).
REQ-012 iss_en (1), iss_addr (ADDR_W)  in  SHALL mark a destination entry busy at issue.

Function
REQ-013 FSM states SHALL be CLEAR and RUN; ready = (state == RUN).
REQ-014 In CLEAR, each cycle SHALL write zero to entry clr_ptr and increment clr_ptr; clr_ptr == DEPTH-1 -> RUN next cycle, so CLEAR lasts exactly DEPTH cycles.
REQ-015 While ready = 0: wr_en0/1 and iss_en SHALL be ignored; rd_data1/2 = 0; rd_busy1/2 = 0.
REQ-016 In RUN, an enabled write port SHALL update its entry at the next rising edge.
REQ-017 Both write ports enabled to the same address: port 1 SHALL win.
REQ-018 Read bypass: if a read address matches an enabled write this cycle, rd_data SHALL return that write data (port 1 before port 0); otherwise, the stored value.
REQ-019 Scoreboard: iss_en SHALL set busy[iss_addr]; an enabled write SHALL clear busy[wr_addr]; the update is visible on the cycle after the edge.
REQ-020 iss_en and a write to the same address in the same cycle: set SHALL win (new producer).
REQ-021 rd_busy SHALL be 0 when the read address matches an enabled write this cycle and not iss_addr with iss_en; otherwise, the registered bit.
REQ-022 ZERO_REG = 1: address 0 SHALL read 0, ignore writes and issues, and report busy 0, including bypass cases.
REQ-023 Addresses SHALL be full-range; no wrap or out-of-range case exists.

Reset
REQ-024 rst_n = 0 at a rising edge SHALL force state = CLEAR, clr_ptr = 0, and all busy bits = 0; ready = 0 from the next cycle.
REQ-025 Reset asserted mid-CLEAR or mid-RUN SHALL restart the full DEPTH-cycle clear after release.
REQ-026 Storage array contents SHALL NOT be reset directly; zeroing comes only from CLEAR.

Structure
REQ-027 Package reg_file_pkg SHALL hold the state enum (CLEAR, RUN) and the default parameter constants.
REQ-028 Busy-bit logic SHALL live in sub-module reg_file_scoreboard (ADDR_W parameter; set/clear/lookup ports); storage, bypass and FSM stay in reg_file_sb.
REQ-029 Implementation SHALL be a single clock domain with no latches and no negedge logic.

Verification
REQ-030 Reset, then hold rst_n = 1 -> ready rises after exactly 16 cycles; all 16 entries read 0x0000.
REQ-031 RUN: wr_en0 to r3 with 0x1234; same cycle, rd_addr1 = 3 -> rd_data1 = 0x1234 (bypass); next cycle, stored value = 0x1234.
REQ-032 wr_en0 to r5 with 0xAAAA and wr_en1 to r5 with 0x5555 in the same cycle -> r5 = 0x5555.
REQ-033 iss_en to r7 -> rd_busy = 1 next cycle; wr_en1 to r7 with 0x00FF -> rd_busy = 0 in the same cycle and after; simultaneous iss and write to r7 -> busy stays 1.
REQ-034 Write 0xFFFF to r0 with iss_en to r0 (ZERO_REG = 1) -> r0 reads 0x0000 and busy reads 0.
REQ-035 Reset at CLEAR cycle 8 after writes to r9 -> ready low for a full 16 cycles again; r9 reads 0 afterwards.
